// File: rtl/instruction_fetcher_pkg.sv
// Shared encodings and widths for the per-core instruction fetch stage.
package instruction_fetcher_pkg;

  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 16;
  localparam int CNT_BITS  = 16;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    FS_IDLE     = 3'b000,
    FS_FETCHING = 3'b001,
    FS_FETCHED  = 3'b010
  } fetch_state_e;

  // Profiling counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == '1) ? v : v + CNT_BITS'(1);
  endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Program-memory read channel between a fetcher and the memory controller.
interface instruction_fetcher_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              mem_read_valid;
  logic [ADDR_W-1:0] mem_read_address;
  logic              mem_read_ready;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data
  );
endinterface

// File: rtl/instruction_fetcher_icache_array.sv
// Direct-mapped instruction cache storage: combinational lookup, one write
// port, and a flush that clears every valid bit (flush beats a same-edge write).
module instruction_fetcher_icache_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LINES  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_hit_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;

  assign rd_idx = rd_addr_i[IDX_W-1:0];
  assign rd_tag = rd_addr_i[ADDR_W-1:IDX_W];
  assign wr_idx = wr_addr_i[IDX_W-1:0];
  assign wr_tag = wr_addr_i[ADDR_W-1:IDX_W];

  assign rd_hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_o = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!reset)       valid_q <= '0;
    else if (flush_i) valid_q <= '0;
    else if (wr_en_i) valid_q[wr_idx] <= 1'b1;
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data_i;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Instruction fetch stage: cache lookup on FETCH, program-memory refill on a
// miss, FETCHED/DECODE handshake with the scheduler, hit/miss profiling.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = ADDR_BITS,
  parameter int PROGRAM_MEM_DATA_BITS = DATA_BITS,
  parameter int CACHE_LINES           = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  instruction_fetcher_if.master            mem,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [CNT_BITS-1:0]              hit_count,
  output logic [CNT_BITS-1:0]              miss_count
);
  fetch_state_e                     state_q, state_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;
  logic                             mvalid_q, mvalid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] maddr_q, maddr_d;
  logic [CNT_BITS-1:0]              hit_q, hit_d, miss_q, miss_d;
  logic                             fill_en;
  logic                             lookup_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] lookup_data;

  instruction_fetcher_icache_array #(
    .ADDR_W (PROGRAM_MEM_ADDR_BITS),
    .DATA_W (PROGRAM_MEM_DATA_BITS),
    .LINES  (CACHE_LINES)
  ) u_icache (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (flush),
    .rd_addr_i (current_pc),
    .rd_hit_o  (lookup_hit),
    .rd_data_o (lookup_data),
    .wr_en_i   (fill_en),
    .wr_addr_i (maddr_q),
    .wr_data_i (mem.mem_read_data)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    mvalid_d = mvalid_q;
    maddr_d  = maddr_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    fill_en  = 1'b0;
    case (state_q)
      FS_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (lookup_hit) begin
            instr_d = lookup_data;
            state_d = FS_FETCHED;
            hit_d   = sat_inc(hit_q);
          end else begin
            mvalid_d = 1'b1;
            maddr_d  = current_pc;
            state_d  = FS_FETCHING;
            miss_d   = sat_inc(miss_q);
          end
        end
      end
      // Once issued, a request always runs to completion regardless of core_state.
      FS_FETCHING: begin
        if (mem.mem_read_ready) begin
          instr_d  = mem.mem_read_data;
          mvalid_d = 1'b0;
          fill_en  = 1'b1;
          state_d  = FS_FETCHED;
        end
      end
      FS_FETCHED: begin
        if (core_state == CORE_DECODE) state_d = FS_IDLE;
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= FS_IDLE;
      instr_q  <= '0;
      mvalid_q <= 1'b0;
      maddr_q  <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      mvalid_q <= mvalid_d;
      maddr_q  <= maddr_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign fetcher_state        = state_q;
  assign instruction          = instr_q;
  assign hit_count            = hit_q;
  assign miss_count           = miss_q;
  assign mem.mem_read_valid   = mvalid_q;
  assign mem.mem_read_address = maddr_q;

endmodule
